// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution sequencer.
package conv_pkg;

  localparam int ADDR_WIDTH_DEF = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ACCUM = 3'd2,
    FLUSH = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } conv_state_t;

endpackage

// File: rtl/conv_index_gen.sv
// Output index n, tap index k, the per-sample k window and the terminal flags.
module conv_index_gen
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rsth,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] size_x,
  input  logic [ADDR_WIDTH-1:0] size_y,
  input  logic                  k_load,
  input  logic                  k_inc,
  input  logic                  n_inc,
  output logic [ADDR_WIDTH-1:0] k,
  output logic [ADDR_WIDTH:0]   n,
  output logic                  k_last,
  output logic                  n_last
);

  localparam int NW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] sx_q;
  logic [ADDR_WIDTH-1:0] sy_q;
  logic [ADDR_WIDTH-1:0] k_q;
  logic [NW-1:0]         n_q;

  logic [NW-1:0] sx_m1;
  logic [NW-1:0] sy_m1;
  logic [NW-1:0] kmin;
  logic [NW-1:0] kmax;
  logic [NW-1:0] n_end;

  // kmin clamps at zero so that n-k can never go negative
  always_comb begin
    sx_m1 = NW'(sx_q) - NW'(1);
    sy_m1 = NW'(sy_q) - NW'(1);
    kmin  = (n_q >= sy_m1) ? (n_q - sy_m1) : '0;
    kmax  = (n_q < sx_m1) ? n_q : sx_m1;
    n_end = NW'(sx_q) + NW'(sy_q) - NW'(2);
  end

  assign k      = k_q;
  assign n      = n_q;
  assign k_last = (NW'(k_q) == kmax);
  assign n_last = (n_q == n_end);

  always_ff @(posedge clk or posedge rsth) begin
    if (rsth) begin
      sx_q <= '0;
      sy_q <= '0;
      k_q  <= '0;
      n_q  <= '0;
    end else begin
      if (load) begin
        sx_q <= size_x;
        sy_q <= size_y;
        n_q  <= '0;
      end else if (n_inc) begin
        n_q <= n_q + NW'(1);
      end
      // k may wrap after the final tap; it is always reloaded in SETUP
      if (k_load) begin
        k_q <= ADDR_WIDTH'(kmin);
      end else if (k_inc) begin
        k_q <= k_q + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Sequences X/Y reads, accumulator control and Z writes for a full linear convolution.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rsth,
  input  logic                  clrh,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] size_x,
  input  logic [ADDR_WIDTH-1:0] size_y,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr_x,
  output logic [ADDR_WIDTH-1:0] addr_y,
  output logic                  mac_clr,
  output logic                  mac_en,
  output logic                  wr_en,
  output logic [ADDR_WIDTH:0]   addr_z,
  output logic                  busy,
  output logic                  done
);

  localparam int NW = ADDR_WIDTH + 1;

  conv_state_t state, nxt;

  logic                  load, k_load, k_inc, n_inc;
  logic                  k_last, n_last;
  logic [ADDR_WIDTH-1:0] k;
  logic [NW-1:0]         n;
  logic [ADDR_WIDTH-1:0] ny;

  logic [ADDR_WIDTH-1:0] ax_hold, ay_hold;
  logic [NW-1:0]         az_hold;
  logic                  rd_en_p0;
  logic                  mac_en_p1;

  conv_index_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_idx (
    .clk    (clk),
    .rsth   (rsth),
    .load   (load),
    .size_x (size_x),
    .size_y (size_y),
    .k_load (k_load),
    .k_inc  (k_inc),
    .n_inc  (n_inc),
    .k      (k),
    .n      (n),
    .k_last (k_last),
    .n_last (n_last)
  );

  always_ff @(posedge clk or posedge rsth) begin
    if (rsth) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt    = state;
    load   = 1'b0;
    k_load = 1'b0;
    k_inc  = 1'b0;
    n_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          nxt  = ((size_x == '0) || (size_y == '0)) ? DONE : SETUP;
        end
      end
      SETUP: begin
        k_load = 1'b1;
        nxt    = ACCUM;
      end
      ACCUM: begin
        k_inc = 1'b1;
        if (k_last) nxt = FLUSH;
      end
      FLUSH: nxt = WRITE;
      WRITE: begin
        if (n_last) begin
          nxt = DONE;
        end else begin
          n_inc = 1'b1;
          nxt   = SETUP;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // abort wins over everything, including a start seen in IDLE
    if (clrh) begin
      nxt    = IDLE;
      load   = 1'b0;
      k_load = 1'b0;
      k_inc  = 1'b0;
      n_inc  = 1'b0;
    end
  end

  assign ny = ADDR_WIDTH'(n - NW'(k));

  // Stage p0: read issue; addresses hold their last driven value outside ACCUM/WRITE
  assign rd_en_p0 = (state == ACCUM);

  always_ff @(posedge clk or posedge rsth) begin
    if (rsth) begin
      ax_hold <= '0;
      ay_hold <= '0;
      az_hold <= '0;
    end else begin
      if (state == ACCUM) begin
        ax_hold <= k;
        ay_hold <= ny;
      end
      if (state == WRITE) az_hold <= n;
    end
  end

  // Stage p1: memory data arrives one cycle after the read, so accumulate then
  always_ff @(posedge clk or posedge rsth) begin
    if (rsth) mac_en_p1 <= 1'b0;
    else      mac_en_p1 <= rd_en_p0;
  end

  assign rd_en   = rd_en_p0;
  assign addr_x  = (state == ACCUM) ? k : ax_hold;
  assign addr_y  = (state == ACCUM) ? ny : ay_hold;
  assign mac_clr = (state == SETUP);
  assign mac_en  = mac_en_p1;
  assign wr_en   = (state == WRITE);
  assign addr_z  = (state == WRITE) ? n : az_hold;
  assign busy    = (state == SETUP) || (state == ACCUM) ||
                   (state == FLUSH) || (state == WRITE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed and randomized checks of conv_sequencer against a cycle-trace reference model.
module tb_conv_sequencer;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rsth, clrh, start;
  logic [AW-1:0] size_x, size_y;
  logic          rd_en, mac_clr, mac_en, wr_en, busy, done;
  logic [AW-1:0] addr_x, addr_y;
  logic [AW:0]   addr_z;

  conv_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rsth    (rsth),
    .clrh    (clrh),
    .start   (start),
    .size_x  (size_x),
    .size_y  (size_y),
    .rd_en   (rd_en),
    .addr_x  (addr_x),
    .addr_y  (addr_y),
    .mac_clr (mac_clr),
    .mac_en  (mac_en),
    .wr_en   (wr_en),
    .addr_z  (addr_z),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy;
    logic          rd;
    logic          mc;
    logic          me;
    logic          wr;
    logic          dn;
    logic [AW-1:0] ax;
    logic [AW-1:0] ay;
    logic [AW:0]   az;
  } rec_t;

  rec_t    exp_q[$];
  rec_t    last_rec;
  int      total = 0;
  int      bad   = 0;
  int      exp_busy;

  logic          m_prev_rd;
  logic [AW-1:0] m_hx, m_hy;
  logic [AW:0]   m_hz;

  function automatic rec_t observe();
    rec_t o;
    o.busy = busy;   o.rd = rd_en;  o.mc = mac_clr; o.me = mac_en;
    o.wr   = wr_en;  o.dn = done;   o.ax = addr_x;  o.ay = addr_y;
    o.az   = addr_z;
    return o;
  endfunction

  task automatic check_rec(input string tag, input rec_t e);
    rec_t o;
    o = observe();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got busy/rd/clr/mac/wr/done=%b%b%b%b%b%b x=%0d y=%0d z=%0d exp %b%b%b%b%b%b x=%0d y=%0d z=%0d",
             tag, o.busy, o.rd, o.mc, o.me, o.wr, o.dn, o.ax, o.ay, o.az,
             e.busy, e.rd, e.mc, e.me, e.wr, e.dn, e.ax, e.ay, e.az);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int expv);
    total++;
    assert (got == expv) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, expv);
    end
  endtask

  task automatic add_rec(input logic b, input logic rd, input logic mc,
                         input logic wr, input logic dn);
    rec_t r;
    r.busy = b;  r.rd = rd; r.mc = mc; r.me = m_prev_rd;
    r.wr   = wr; r.dn = dn; r.ax = m_hx; r.ay = m_hy; r.az = m_hz;
    m_prev_rd = rd;
    exp_q.push_back(r);
  endtask

  // Expected cycle trace from the convolution index rules, starting at the cycle after start
  task automatic build(input int sx, input int sy);
    int lo, hi;
    exp_q.delete();
    exp_busy  = 0;
    m_prev_rd = 1'b0;
    m_hx = last_rec.ax; m_hy = last_rec.ay; m_hz = last_rec.az;
    if (sx == 0 || sy == 0) begin
      add_rec(0, 0, 0, 0, 1);
    end else begin
      for (int n = 0; n <= sx + sy - 2; n++) begin
        lo = (n - sy + 1 > 0) ? n - sy + 1 : 0;
        hi = (n < sx - 1) ? n : sx - 1;
        exp_busy += (hi - lo + 1) + 3;
        add_rec(1, 0, 1, 0, 0);
        for (int k = lo; k <= hi; k++) begin
          m_hx = AW'(k);
          m_hy = AW'(n - k);
          add_rec(1, 1, 0, 0, 0);
        end
        add_rec(1, 0, 0, 0, 0);
        m_hz = (AW+1)'(n);
        add_rec(1, 0, 0, 1, 0);
      end
      add_rec(0, 0, 0, 0, 1);
    end
    add_rec(0, 0, 0, 0, 0);
  endtask

  // Called at a negedge; abort_at/rst_at select the record after which clrh or rsth hits
  task automatic run_seq(input int sx, input int sy, input int abort_at, input int rst_at);
    int   wr_n, rd_n, me_n, bz_n, nrec;
    rec_t e;
    string tag;
    build(sx, sy);
    nrec   = exp_q.size();
    size_x = AW'(sx);
    size_y = AW'(sy);
    start  = 1'b1;
    wr_n = 0; rd_n = 0; me_n = 0; bz_n = 0;
    for (int i = 0; i < nrec; i++) begin
      @(negedge clk);
      tag = $sformatf("s%0dx%0d_c%0d", sx, sy, i);
      check_rec(tag, exp_q[i]);
      wr_n += int'(wr_en); rd_n += int'(rd_en); me_n += int'(mac_en); bz_n += int'(busy);
      last_rec = exp_q[i];
      start  = (i == nrec - 1) ? 1'b0 : 1'(($urandom_range(0, 1)));
      size_x = AW'($urandom);
      size_y = AW'($urandom);
      if (i == abort_at) begin
        clrh  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        e = last_rec;
        e.busy = 0; e.rd = 0; e.mc = 0; e.wr = 0; e.dn = 0; e.me = last_rec.rd;
        check_rec({tag, "_clr"}, e);
        clrh  = 1'b0;
        start = 1'b0;
        e.me  = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check_rec($sformatf("%s_clr_idle%0d", tag, j), e);
        end
        last_rec = e;
        return;
      end
      if (i == rst_at) begin
        start = 1'b0;
        #2 rsth = 1'b1;
        #1 check_rec({tag, "_rst_async"}, '0);
        @(negedge clk);
        check_rec({tag, "_rst_hold"}, '0);
        rsth     = 1'b0;
        last_rec = '0;
        return;
      end
    end
    check_int($sformatf("s%0dx%0d_writes", sx, sy), wr_n,
              (sx == 0 || sy == 0) ? 0 : sx + sy - 1);
    check_int($sformatf("s%0dx%0d_busy", sx, sy), bz_n, exp_busy);
    check_int($sformatf("s%0dx%0d_mac_vs_rd", sx, sy), me_n, rd_n);
  endtask

  initial begin
    rsth = 1'b1; clrh = 1'b0; start = 1'b0;
    size_x = '0; size_y = '0;
    last_rec = '0;
    #12;
    check_rec("reset_state", '0);
    start = 1'b1; size_x = 5'd2; size_y = 5'd2;
    @(negedge clk);
    check_rec("reset_ignores_start", '0);
    start = 1'b0;
    @(negedge clk);
    rsth = 1'b0;

    // first start on the edge right after reset release
    run_seq(1, 1, -1, -1);
    run_seq(3, 2, -1, -1);
    run_seq(0, 4, -1, -1);
    run_seq(4, 0, -1, -1);
    run_seq(2, 5, -1, -1);
    // clrh with start during the second sample's first ACCUM cycle
    run_seq(3, 2, 5, -1);
    run_seq(2, 2, -1, -1);
    // async reset mid-ACCUM, then a full run right after release
    run_seq(4, 3, -1, 11);
    run_seq(4, 3, -1, -1);
    run_seq(31, 31, -1, -1);
    for (int r = 0; r < 6; r++) begin
      run_seq(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, width of the X/Y sample addresses and size inputs.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rsth, input, 1, the reset, asynchronous and active-high.
REQ-004 The block SHALL have port clrh, input, 1, synchronous abort, active-high.
REQ-005 The block SHALL have port start, input, 1, a pulse that launches a convolution.
REQ-006 The block SHALL have ports size_x and size_y, input, ADDR_WIDTH each, giving the X and Y sample counts.
REQ-007 The block SHALL have ports rd_en (1), addr_x (ADDR_WIDTH) and addr_y (ADDR_WIDTH), all outputs, driving the read of the X and Y memories.
REQ-008 The block SHALL have ports mac_clr (1) and mac_en (1), both outputs, controlling the accumulator.
REQ-009 The block SHALL have ports wr_en (1) and addr_z (ADDR_WIDTH+1), both outputs, controlling the write of Z results.
REQ-010 The block SHALL have ports busy (1) and done (1), both outputs, reporting status.

Function
REQ-011 The block SHALL compute z[n] = sum of x[k]*y[n-k] for n = 0..size_x+size_y-2, with k running from kmin = max(0, n-size_y+1) to kmax = min(n, size_x-1) in ascending order.
REQ-012 The block SHALL use these states: IDLE, SETUP, ACCUM, FLUSH, WRITE, DONE.
REQ-013 In IDLE, start=1 SHALL latch size_x and size_y, set n=0 and move to SETUP. If either latched size is 0, it SHALL move to DONE instead.
REQ-014 While the state is not IDLE, start SHALL be ignored.
REQ-015 SETUP SHALL last one cycle, with mac_clr=1 and k loaded with kmin, then move to ACCUM.
REQ-016 Each ACCUM cycle SHALL drive rd_en=1, addr_x=k and addr_y=n-k, then increment k. The state SHALL move to FLUSH after the cycle in which k equals kmax.
REQ-017 mac_en SHALL be rd_en delayed by one register stage, covering the one-cycle memory read latency, so it is high in ACCUM cycles 2..L and in FLUSH.
REQ-018 FLUSH SHALL last one cycle and then move to WRITE.
REQ-019 WRITE SHALL last one cycle, with wr_en=1 and addr_z=n.
REQ-020 From WRITE, the state SHALL move to DONE if n = size_x+size_y-2; otherwise n SHALL be incremented and the state SHALL move to SETUP.
REQ-021 DONE SHALL assert done=1 for exactly one cycle and then move to IDLE.
REQ-022 busy SHALL be 1 in SETUP, ACCUM, FLUSH and WRITE, and 0 otherwise.
REQ-023 Each output sample with L terms SHALL take exactly L+3 cycles (SETUP + L×ACCUM + FLUSH + WRITE).
REQ-024 n-k arithmetic SHALL be unsigned and SHALL never underflow, as guaranteed by kmin.
REQ-025 The n counter SHALL be ADDR_WIDTH+1 bits wide so that the maximum n = 2*(2^ADDR_WIDTH-1)-2 never wraps.
REQ-026 clrh=1 SHALL force IDLE on the next edge from any state. It SHALL suppress done and wr_en in that cycle and SHALL take priority over a simultaneous start.
REQ-027 Outputs not asserted by the current state SHALL be 0. addr_x, addr_y and addr_z SHALL hold their last value.

Reset
REQ-028 rsth=1 SHALL immediately force IDLE, clear k, n and the latched sizes, and drive all outputs to 0, including mid-operation.
REQ-029 After rsth is deasserted, the block SHALL accept start on the first clock edge.

Structure
REQ-030 The package conv_pkg SHALL hold the state enum type conv_state_t and the default ADDR_WIDTH constant.
REQ-031 One sub-module, conv_index_gen, SHALL hold the k and n counters, the kmin/kmax computation and the terminal flags. The FSM SHALL stay in conv_sequencer.
REQ-032 All outputs SHALL be registered or decoded from state only, with no combinational path from start or clrh to any output.

Verification
REQ-033 size_x=1, size_y=1, start -> SETUP, ACCUM(addr 0/0), FLUSH, WRITE(addr_z=0), then done one cycle later; busy high for 4 cycles.
REQ-034 size_x=3, size_y=2 -> exactly 4 writes with addr_z 0..3; read pairs (0,0) | (0,1),(1,0) | (1,1),(2,0) | (2,1); busy high for 18 cycles.
REQ-035 size_x=0, size_y=4 -> done one cycle after start; no rd_en or wr_en pulses; busy stays 0.
REQ-036 clrh pulsed during the second sample's ACCUM, with start high in the same cycle -> IDLE next cycle, no done, no further wr_en, and that start is ignored.
REQ-037 rsth asserted asynchronously between edges mid-ACCUM -> all outputs 0 immediately; a new start after release runs a full, correct sequence.
REQ-038 size_x=31, size_y=31 -> 61 writes with addr_z 0..60 and no counter wrap; mac_en count equals rd_en count for every sample.
